// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue queue: opcode encodings, flag bit
// positions and the packed operation record.
package alu_pkg;

    localparam int OPC_W = 3;
    localparam int ALU_W = 4;

    localparam logic [OPC_W-1:0] OP_ADD = 3'b000;
    localparam logic [OPC_W-1:0] OP_SUB = 3'b001;
    localparam logic [OPC_W-1:0] OP_AND = 3'b010;
    localparam logic [OPC_W-1:0] OP_OR  = 3'b011;
    localparam logic [OPC_W-1:0] OP_XOR = 3'b100;
    localparam logic [OPC_W-1:0] OP_NOT = 3'b101;
    localparam logic [OPC_W-1:0] OP_SHL = 3'b110;
    localparam logic [OPC_W-1:0] OP_SHR = 3'b111;

    // Bit of the ALU flag vector that reports adder overflow.
    localparam int FLAG_OVF_BIT = 2;

    // Operation record at the default ALU width; modules built for another W
    // declare the same layout with their own width.
    typedef struct packed {
        logic [ALU_W-1:0] a;
        logic [ALU_W-1:0] b;
        logic [OPC_W-1:0] opcode;
    } alu_op_t;

    // Saturating 8-bit increment used by the overflow event counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/alu_issue_queue_if.sv
// Operation-in and result-out streams of the ALU issue queue.
//
// Both streams use valid/ready: a transfer happens on a rising clock edge
// where valid and ready are both high. The sender keeps valid and its data
// stable until that edge; ready may be raised or dropped at any time.
interface alu_issue_queue_if #(parameter int W = 4);
    import alu_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_A;
    logic [W-1:0]     in_B;
    logic [OPC_W-1:0] in_Opcode;

    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_result;
    logic [2:0]       out_flag;
    logic [OPC_W-1:0] out_Opcode;

    // Producer of operations and consumer of results.
    modport master (
        output in_valid, in_A, in_B, in_Opcode,
        input  in_ready,
        input  out_valid, out_result, out_flag, out_Opcode,
        output out_ready
    );

    // The issue queue itself.
    modport slave (
        input  in_valid, in_A, in_B, in_Opcode,
        output in_ready,
        output out_valid, out_result, out_flag, out_Opcode,
        input  out_ready
    );

endinterface

// File: rtl/alu_op_fifo.sv
// Operation FIFO: DEPTH entries (power of two), wrapping pointers and an
// occupancy counter. Pushes into a full FIFO and pops from an empty one are
// ignored. No read-through: a pushed entry becomes visible at the head on the
// following cycle.
module alu_op_fifo
    import alu_pkg::*;
#(
    parameter int DW    = 2 * ALU_W + OPC_W,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o,
    output logic [AW:0]   count_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Next pointers and occupancy; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/alu_issue_queue.sv
// Clocked, back-pressurable front end for an external combinational ALU.
// Operations queue in a FIFO, issue one per cycle through a registered stage
// that drives the ALU inputs, and the ALU result is captured into a held
// output register.
//
// Optional: define ALU_ISSUE_OVF_CNT_EN to add a saturating 8-bit count of
// captured results whose overflow flag was set, with a synchronous clear.
module alu_issue_queue
    import alu_pkg::*;
#(
    parameter int W     = 4,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_issue_queue_if.slave bus,
    output logic [W-1:0]     alu_A,
    output logic [W-1:0]     alu_B,
    output logic [OPC_W-1:0] alu_Opcode,
    input  logic [W-1:0]     alu_result,
    input  logic [2:0]       alu_flag,
    output logic [AW:0]      count
`ifdef ALU_ISSUE_OVF_CNT_EN
    ,
    input  logic             ovf_clr,
    output logic [7:0]       ovf_cnt
`endif
);

    typedef struct packed {
        logic [W-1:0]     a;
        logic [W-1:0]     b;
        logic [OPC_W-1:0] opcode;
    } op_t;

    op_t              push_op, head_op;
    logic             fifo_full, fifo_empty;
    logic             push, pop, out_adv, iss_adv;

    logic             issue_valid_q, issue_valid_d;
    op_t              iss_op_q, iss_op_d;

    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     out_result_q, out_result_d;
    logic [2:0]       out_flag_q, out_flag_d;
    logic [OPC_W-1:0] out_opcode_q, out_opcode_d;

    // in_ready looks only at registered occupancy, so a pop never opens a
    // slot in the same cycle.
    assign bus.in_ready = !fifo_full;
    assign push         = bus.in_valid && !fifo_full;
    assign out_adv      = !out_valid_q || bus.out_ready;
    assign iss_adv      = !issue_valid_q || out_adv;
    assign pop          = iss_adv && !fifo_empty;
    assign push_op      = '{a: bus.in_A, b: bus.in_B, opcode: bus.in_Opcode};

    alu_op_fifo #(
        .DW    ($bits(op_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (push_op),
        .rdata_o (head_op),
        .count_o (count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Issue and output stage next state; data holds on bubbles.
    always_comb begin
        issue_valid_d = issue_valid_q;
        iss_op_d      = iss_op_q;
        out_valid_d   = out_valid_q;
        out_result_d  = out_result_q;
        out_flag_d    = out_flag_q;
        out_opcode_d  = out_opcode_q;
        if (iss_adv) begin
            issue_valid_d = !fifo_empty;
            if (!fifo_empty) iss_op_d = head_op;
        end
        if (out_adv) begin
            out_valid_d = issue_valid_q;
            if (issue_valid_q) begin
                out_result_d = alu_result;
                out_flag_d   = alu_flag;
                out_opcode_d = iss_op_q.opcode;
            end
        end
    end

    // Issue and output stage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_valid_q <= 1'b0;
            iss_op_q      <= '0;
            out_valid_q   <= 1'b0;
            out_result_q  <= '0;
            out_flag_q    <= '0;
            out_opcode_q  <= '0;
        end else begin
            issue_valid_q <= issue_valid_d;
            iss_op_q      <= iss_op_d;
            out_valid_q   <= out_valid_d;
            out_result_q  <= out_result_d;
            out_flag_q    <= out_flag_d;
            out_opcode_q  <= out_opcode_d;
        end
    end

    assign alu_A          = iss_op_q.a;
    assign alu_B          = iss_op_q.b;
    assign alu_Opcode     = iss_op_q.opcode;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;
    assign bus.out_flag   = out_flag_q;
    assign bus.out_Opcode = out_opcode_q;

`ifdef ALU_ISSUE_OVF_CNT_EN
    logic [7:0] ovf_cnt_q, ovf_cnt_d;

    // Count overflowing captures; clear takes priority over an increment.
    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (ovf_clr) begin
            ovf_cnt_d = '0;
        end else if (out_adv && issue_valid_q && alu_flag[FLAG_OVF_BIT]) begin
            ovf_cnt_d = sat_inc8(ovf_cnt_q);
        end
    end

    // Overflow counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_cnt_q <= '0;
        else        ovf_cnt_q <= ovf_cnt_d;
    end

    assign ovf_cnt = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue with a behavioural ALU on the alu_* side.
// Exercises the ALU_ISSUE_OVF_CNT_EN counter when that macro is defined.
module tb_alu_issue_queue;
    import alu_pkg::*;

    localparam int W     = 4;
    localparam int DEPTH = 4;
    localparam int AW    = $clog2(DEPTH);

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0]     alu_A, alu_B, alu_result;
    logic [OPC_W-1:0] alu_Opcode;
    logic [2:0]       alu_flag;
    logic [AW:0]      count;
    logic [W:0]       alu_sum;
`ifdef ALU_ISSUE_OVF_CNT_EN
    logic             ovf_clr;
    logic [7:0]       ovf_cnt;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    logic [9:0]  exp_q[$];
    logic [10:0] bp_in  [7];
    logic [9:0]  bp_exp [7];
    logic [10:0] wr_in  [10];
    logic [9:0]  wr_exp [10];

    alu_issue_queue_if #(.W(W)) bus();

    alu_issue_queue #(.W(W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .alu_A      (alu_A),
        .alu_B      (alu_B),
        .alu_Opcode (alu_Opcode),
        .alu_result (alu_result),
        .alu_flag   (alu_flag),
        .count      (count)
`ifdef ALU_ISSUE_OVF_CNT_EN
        ,
        .ovf_clr    (ovf_clr),
        .ovf_cnt    (ovf_cnt)
`endif
    );

    // Behavioural ALU: flag bit 2 is the adder carry-out, other bits zero.
    always_comb begin
        alu_sum    = '0;
        alu_result = '0;
        alu_flag   = '0;
        case (alu_Opcode)
            OP_ADD: begin
                alu_sum    = {1'b0, alu_A} + {1'b0, alu_B};
                alu_result = alu_sum[W-1:0];
                alu_flag   = {alu_sum[W], 2'b00};
            end
            OP_SUB:  alu_result = alu_A - alu_B;
            OP_AND:  alu_result = alu_A & alu_B;
            OP_OR:   alu_result = alu_A | alu_B;
            OP_XOR:  alu_result = alu_A ^ alu_B;
            OP_NOT:  alu_result = ~alu_A;
            OP_SHL:  alu_result = alu_A << 1;
            default: alu_result = alu_A >> 1;
        endcase
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [10:0] v);
        bus.in_valid  = 1'b1;
        bus.in_A      = v[10:7];
        bus.in_B      = v[6:3];
        bus.in_Opcode = v[2:0];
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] out_word();
        return {bus.out_result, bus.out_flag, bus.out_Opcode};
    endfunction

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        // {A, B, Opcode} and expected {result, flag, Opcode}
        bp_in[0] = {4'h3, 4'h4, OP_ADD}; bp_exp[0] = {4'h7, 3'b000, OP_ADD};
        bp_in[1] = {4'h5, 4'h7, OP_SUB}; bp_exp[1] = {4'hE, 3'b000, OP_SUB};
        bp_in[2] = {4'hC, 4'hA, OP_AND}; bp_exp[2] = {4'h8, 3'b000, OP_AND};
        bp_in[3] = {4'h3, 4'h8, OP_OR};  bp_exp[3] = {4'hB, 3'b000, OP_OR};
        bp_in[4] = {4'hF, 4'h5, OP_XOR}; bp_exp[4] = {4'hA, 3'b000, OP_XOR};
        bp_in[5] = {4'h8, 4'h8, OP_ADD}; bp_exp[5] = {4'h0, 3'b100, OP_ADD};
        bp_in[6] = {4'h1, 4'h2, OP_OR};  bp_exp[6] = {4'h3, 3'b000, OP_OR};

        wr_in[0] = {4'h9, 4'h3, OP_SUB}; wr_exp[0] = {4'h6, 3'b000, OP_SUB};
        wr_in[1] = {4'h6, 4'h3, OP_AND}; wr_exp[1] = {4'h2, 3'b000, OP_AND};
        wr_in[2] = {4'h6, 4'h3, OP_OR};  wr_exp[2] = {4'h7, 3'b000, OP_OR};
        wr_in[3] = {4'hA, 4'h6, OP_XOR}; wr_exp[3] = {4'hC, 3'b000, OP_XOR};
        wr_in[4] = {4'h5, 4'h0, OP_NOT}; wr_exp[4] = {4'hA, 3'b000, OP_NOT};
        wr_in[5] = {4'h9, 4'h0, OP_SHL}; wr_exp[5] = {4'h2, 3'b000, OP_SHL};
        wr_in[6] = {4'h9, 4'h0, OP_SHR}; wr_exp[6] = {4'h4, 3'b000, OP_SHR};
        wr_in[7] = {4'h2, 4'h5, OP_SUB}; wr_exp[7] = {4'hD, 3'b000, OP_SUB};
        wr_in[8] = {4'hF, 4'h0, OP_NOT}; wr_exp[8] = {4'h0, 3'b000, OP_NOT};
        wr_in[9] = {4'hC, 4'h0, OP_SHR}; wr_exp[9] = {4'h6, 3'b000, OP_SHR};

        bus.in_valid  = 1'b0;
        bus.in_A      = '0;
        bus.in_B      = '0;
        bus.in_Opcode = '0;
        bus.out_ready = 1'b1;
`ifdef ALU_ISSUE_OVF_CNT_EN
        ovf_clr = 1'b0;
`endif

        // Reset values
        repeat (3) tick();
        check("rst_count", 32'(count), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_word", 32'(out_word()), 32'd0);
        check("rst_alu_ops", 32'({alu_A, alu_B, alu_Opcode}), 32'd0);
        rst_n = 1'b1;
        tick();

        // ADD 7+9 with latency check: accepted edge n, valid at edge n+2
        drive_op({4'h7, 4'h9, OP_ADD});
        tick();
        bus.in_valid = 1'b0;
        check("add_n_valid", 32'(bus.out_valid), 32'd0);
        check("add_n_count", 32'(count), 32'd1);
        tick();
        check("add_n1_valid", 32'(bus.out_valid), 32'd0);
        check("add_n1_alu", 32'({alu_A, alu_B, alu_Opcode}), 32'({4'h7, 4'h9, OP_ADD}));
        tick();
        check("add_n2_valid", 32'(bus.out_valid), 32'd1);
        check("add_n2_word", 32'(out_word()), 32'({4'h0, 3'b100, OP_ADD}));
        tick();
        check("add_n3_valid", 32'(bus.out_valid), 32'd0);

        // Back-pressure: 7 offered, 6 accepted
        bus.out_ready = 1'b0;
        for (int k = 0; k < 7; k++) begin
            drive_op(bp_in[k]);
            check($sformatf("bp_in_ready_%0d", k), 32'(bus.in_ready), (k < 6) ? 32'd1 : 32'd0);
            tick();
        end
        bus.in_valid = 1'b0;
        check("bp_count_full", 32'(count), 32'd4);
        check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
        check("bp_held_valid", 32'(bus.out_valid), 32'd1);
        check("bp_held_word0", 32'(out_word()), 32'(bp_exp[0]));
        tick();
        check("bp_stable_word", 32'(out_word()), 32'(bp_exp[0]));
        check("bp_stable_count", 32'(count), 32'd4);
        bus.out_ready = 1'b1;
        for (int k = 1; k < 6; k++) begin
            tick();
            check($sformatf("bp_drain_valid_%0d", k), 32'(bus.out_valid), 32'd1);
            check($sformatf("bp_drain_word_%0d", k), 32'(out_word()), 32'(bp_exp[k]));
        end
        tick();
        check("bp_no_extra", 32'(bus.out_valid), 32'd0);
        check("bp_count_empty", 32'(count), 32'd0);

        // Pointer wrap: continuous stream of 10 ops
        for (int k = 0; k < 10; k++) exp_q.push_back(wr_exp[k]);
        for (int k = 0; k < 14; k++) begin
            if (k < 10) drive_op(wr_in[k]);
            else bus.in_valid = 1'b0;
            tick();
            check($sformatf("wr_count_le1_%0d", k), 32'(count <= 1), 32'd1);
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    check("wr_extra_output", 32'(bus.out_valid), 32'd0);
                end else begin
                    check($sformatf("wr_word_%0d", k), 32'(out_word()), 32'(exp_q.pop_front()));
                end
            end
        end
        check("wr_all_seen", 32'(exp_q.size()), 32'd0);

        // Full FIFO with a pop in the same cycle as an offered push
        bus.out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            drive_op(bp_in[k]);
            tick();
        end
        check("full_count", 32'(count), 32'd4);
        drive_op({4'h1, 4'h1, OP_ADD});
        bus.out_ready = 1'b1;
        check("full_pop_cycle_count", 32'(count), 32'd4);
        check("full_pop_cycle_ready", 32'(bus.in_ready), 32'd0);
        tick();
        check("after_pop_count", 32'(count), 32'd3);
        check("after_pop_ready", 32'(bus.in_ready), 32'd1);
        check("after_pop_word", 32'(out_word()), 32'(bp_exp[1]));
        tick();
        bus.in_valid = 1'b0;
        check("push_pop_count", 32'(count), 32'd3);
        check("push_pop_word", 32'(out_word()), 32'(bp_exp[2]));
        for (int k = 3; k < 7; k++) begin
            tick();
            check($sformatf("full_drain_%0d", k), 32'(out_word()),
                  (k < 6) ? 32'(bp_exp[k]) : 32'({4'h2, 3'b000, OP_ADD}));
        end
        tick();
        check("full_drain_done", 32'(bus.out_valid), 32'd0);

        // Bubble: idle cycles hold ALU operands and output data
        repeat (3) tick();
        check("bubble_valid", 32'(bus.out_valid), 32'd0);
        check("bubble_alu_hold", 32'({alu_A, alu_B, alu_Opcode}), 32'({4'h1, 4'h1, OP_ADD}));
        check("bubble_data_hold", 32'(bus.out_result), 32'h2);

        // Reset mid-stream discards everything
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive_op(bp_in[k]);
            tick();
        end
        bus.in_valid = 1'b0;
        check("mid_pre_valid", 32'(bus.out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_alu", 32'({alu_A, alu_B, alu_Opcode}), 32'd0);
        tick();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("mid_quiet_%0d", k), 32'({bus.out_valid, count}), 32'd0);
        end
        drive_op({4'h2, 4'h3, OP_ADD});
        tick();
        bus.in_valid = 1'b0;
        tick();
        check("mid_new_n1", 32'(bus.out_valid), 32'd0);
        tick();
        check("mid_new_valid", 32'(bus.out_valid), 32'd1);
        check("mid_new_word", 32'(out_word()), 32'({4'h5, 3'b000, OP_ADD}));
        tick();

`ifdef ALU_ISSUE_OVF_CNT_EN
        // Overflow counter saturation and clear priority
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_cleared", 32'(ovf_cnt), 32'd0);
        drive_op({4'hF, 4'h1, OP_ADD});
        repeat (300) tick();
        bus.in_valid = 1'b0;
        repeat (3) tick();
        check("ovf_saturated", 32'(ovf_cnt), 32'hFF);
        check("ovf_drained", 32'(count), 32'd0);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        drive_op({4'hF, 4'h1, OP_ADD});
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        check("ovf_single", 32'(ovf_cnt), 32'd1);
        drive_op({4'hF, 4'h1, OP_ADD});
        tick();
        bus.in_valid = 1'b0;
        tick();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_clr_wins", 32'(ovf_cnt), 32'd0);
        check("ovf_clr_capture", 32'(out_word()), 32'({4'h0, 3'b100, OP_ADD}));
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
